timer_entry_loader: RTL and testbench

//   Microwave keypad-entry side of the countdown chain: collects decimal key digits into an MM:SS

---
 rtl/timer_entry_loader_pkg.sv | 26 ++
 rtl/timer_entry_loader_key_edge_detect.sv | 29 ++
 rtl/timer_entry_loader.sv | 158 +++++++++++++++
 tb/tb_timer_entry_loader.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_entry_loader_pkg.sv
`default_nettype none
// Shared types and constants for the microwave keypad-entry / countdown-load block.
package timer_entry_loader_pkg;

  localparam int BCD_W      = 4;
  localparam int SEC_TENS_W = 3;
  localparam int BUF_W      = 4 * BCD_W;

  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // A loadable entry needs a legal seconds-tens digit and a non-zero time.
  function automatic logic entry_is_valid(input logic [BUF_W-1:0] b);
    return (b[7:4] <= SEC_TENS_MAX) && (b != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_entry_loader_key_edge_detect.sv
`default_nettype none
// Rising-edge detector for a level key/button strobe; pulse is high for the
// first cycle the input is seen high.
module key_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic key_valid,
  output logic key_pulse
);

  logic key_prev_q;
  logic key_prev_d;

  always_comb begin
    key_prev_d = key_valid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_prev_q <= 1'b0;
    end else begin
      key_prev_q <= key_prev_d;
    end
  end

  assign key_pulse = key_valid & ~key_prev_q;

endmodule
`default_nettype wire

// File: rtl/timer_entry_loader.sv
`default_nettype none
// Keypad entry buffer (MM:SS) and load/run/done sequencer for the mod-10/mod-6
// countdown cascade.
module timer_entry_loader
  import timer_entry_loader_pkg::*;
#(
  parameter int DONE_CYCLES = 3,
  parameter int MAX_DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [BCD_W-1:0]      key_digit,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  timer_done,
  output logic [BCD_W-1:0]      data_sec_ones,
  output logic [SEC_TENS_W-1:0] data_sec_tens,
  output logic [BCD_W-1:0]      data_min_ones,
  output logic [BCD_W-1:0]      data_min_tens,
  output logic                  load,
  output logic                  run,
  output logic                  done,
  output logic                  err
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int DC_W  = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_DIGITS);
  localparam logic [DC_W-1:0]  DONE_INIT = DC_W'(DONE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DC_W-1:0]    done_cnt_q, done_cnt_d;
  logic               load_q, load_d;
  logic               run_q, run_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               key_pulse;
  logic               key_ok;

  key_edge_detect u_key_edge (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_pulse (key_pulse)
  );

  assign key_ok = key_pulse && (key_digit <= DIGIT_MAX) && (count_q < MAX_CNT);

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    count_d    = count_q;
    done_cnt_d = done_cnt_q;
    load_d     = 1'b0;
    run_d      = run_q;
    done_d     = done_q;
    err_d      = 1'b0;

    if (clear) begin
      state_d    = ST_IDLE;
      buf_d      = '0;
      count_d    = '0;
      done_cnt_d = '0;
      run_d      = 1'b0;
      done_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_ok) begin
            buf_d   = {buf_q[BUF_W-BCD_W-1:0], key_digit};
            count_d = count_q + 1'b1;
            state_d = ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          // start outranks a key arriving in the same cycle; that key is dropped.
          if (start) begin
            if (entry_is_valid(buf_q)) begin
              state_d = ST_LOAD;
              load_d  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (key_ok) begin
            buf_d   = {buf_q[BUF_W-BCD_W-1:0], key_digit};
            count_d = count_q + 1'b1;
          end
        end
        ST_LOAD: begin
          state_d = ST_RUN;
          run_d   = 1'b1;
        end
        ST_RUN: begin
          if (timer_done) begin
            state_d    = ST_DONE;
            run_d      = 1'b0;
            done_d     = 1'b1;
            done_cnt_d = DONE_INIT;
          end
        end
        ST_DONE: begin
          if (done_cnt_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            buf_d   = '0;
            count_d = '0;
          end else begin
            done_cnt_d = done_cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          buf_d   = '0;
          count_d = '0;
          run_d   = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      count_q    <= '0;
      done_cnt_q <= '0;
      load_q     <= 1'b0;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      count_q    <= count_d;
      done_cnt_q <= done_cnt_d;
      load_q     <= load_d;
      run_q      <= run_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign data_sec_ones = buf_q[3:0];
  assign data_sec_tens = buf_q[6:4];
  assign data_min_ones = buf_q[11:8];
  assign data_min_tens = buf_q[15:12];
  assign load          = load_q;
  assign run           = run_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_entry_loader.sv
`default_nettype none
// Directed, table-driven bench for timer_entry_loader.
module tb_timer_entry_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       clear;
  logic       timer_done;
  logic [3:0] data_sec_ones;
  logic [2:0] data_sec_tens;
  logic [3:0] data_min_ones;
  logic [3:0] data_min_tens;
  logic       load;
  logic       run;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timer_entry_loader #(.DONE_CYCLES(3), .MAX_DIGITS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .key_valid     (key_valid),
    .key_digit     (key_digit),
    .start         (start),
    .clear         (clear),
    .timer_done    (timer_done),
    .data_sec_ones (data_sec_ones),
    .data_sec_tens (data_sec_tens),
    .data_min_ones (data_min_ones),
    .data_min_tens (data_min_tens),
    .load          (load),
    .run           (run),
    .done          (done),
    .err           (err)
  );

  // Outputs packed as {sec_ones, sec_tens, min_ones, min_tens, load, run, done, err}
  typedef struct {
    logic        kv;
    logic [3:0]  kd;
    logic        st;
    logic        cl;
    logic        td;
    logic [18:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic logic [18:0] pk(int so, int stn, int mo, int mt, int flags);
    return {4'(so), 3'(stn), 4'(mo), 4'(mt), 4'(flags)};
  endfunction

  function automatic vec_t mk(int kv, int kd, int st, int cl, int td,
                              int so, int stn, int mo, int mt, int flags);
    vec_t v;
    v.kv  = 1'(kv);
    v.kd  = 4'(kd);
    v.st  = 1'(st);
    v.cl  = 1'(cl);
    v.td  = 1'(td);
    v.exp = pk(so, stn, mo, mt, flags);
    return v;
  endfunction

  function automatic logic [18:0] act();
    return {data_sec_ones, data_sec_tens, data_min_ones, data_min_tens, load, run, done, err};
  endfunction

  task automatic check(input string name, input logic [18:0] a, input logic [18:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, a, e);
    end
  endtask

  task automatic cyc(input logic kv, input logic [3:0] kd, input logic st,
                     input logic cl, input logic td);
    @(negedge clk);
    key_valid  = kv;
    key_digit  = kd;
    start      = st;
    clear      = cl;
    timer_done = td;
    @(posedge clk);
    #1;
  endtask

  // flags: 8=load 4=run 2=done 1=err
  initial begin
    reset = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    start = 1'b0; clear = 1'b0; timer_done = 1'b0;

    // 1: keys 1,3,0 -> 01:30
    vq.push_back(mk(1,1,0,0,0, 1,0,0,0, 0));
    vq.push_back(mk(0,0,0,0,0, 1,0,0,0, 0));
    vq.push_back(mk(1,3,0,0,0, 3,1,0,0, 0));
    vq.push_back(mk(0,0,0,0,0, 3,1,0,0, 0));
    vq.push_back(mk(1,0,0,0,0, 0,3,1,0, 0));
    vq.push_back(mk(0,0,0,0,0, 0,3,1,0, 0));
    // 2: start -> load one cycle -> run; key/start in RUN ignored; done 3 cycles
    vq.push_back(mk(0,0,1,0,0, 0,3,1,0, 8));
    vq.push_back(mk(0,0,0,0,0, 0,3,1,0, 4));
    vq.push_back(mk(1,9,1,0,0, 0,3,1,0, 4));
    vq.push_back(mk(0,0,0,0,1, 0,3,1,0, 2));
    vq.push_back(mk(0,0,0,0,0, 0,3,1,0, 2));
    vq.push_back(mk(0,0,0,0,0, 0,3,1,0, 2));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0, 0));
    // 3: keys 0,0,9,0 -> sec_tens 9 rejected
    vq.push_back(mk(1,0,0,0,0, 0,0,0,0, 0));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0, 0));
    vq.push_back(mk(1,0,0,0,0, 0,0,0,0, 0));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0, 0));
    vq.push_back(mk(1,9,0,0,0, 9,0,0,0, 0));
    vq.push_back(mk(0,0,0,0,0, 9,0,0,0, 0));
    vq.push_back(mk(1,0,0,0,0, 0,1,0,0, 0));
    vq.push_back(mk(0,0,0,0,0, 0,1,0,0, 0));
    vq.push_back(mk(0,0,1,0,0, 0,1,0,0, 1));
    vq.push_back(mk(0,0,0,0,0, 0,1,0,0, 0));
    vq.push_back(mk(0,0,0,1,0, 0,0,0,0, 0));
    vq.push_back(mk(0,0,1,0,0, 0,0,0,0, 0));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0, 0));
    // 4: five keys -> 12:34, fifth ignored
    vq.push_back(mk(1,1,0,0,0, 1,0,0,0, 0));
    vq.push_back(mk(0,0,0,0,0, 1,0,0,0, 0));
    vq.push_back(mk(1,2,0,0,0, 2,1,0,0, 0));
    vq.push_back(mk(0,0,0,0,0, 2,1,0,0, 0));
    vq.push_back(mk(1,3,0,0,0, 3,2,1,0, 0));
    vq.push_back(mk(0,0,0,0,0, 3,2,1,0, 0));
    vq.push_back(mk(1,4,0,0,0, 4,3,2,1, 0));
    vq.push_back(mk(0,0,0,0,0, 4,3,2,1, 0));
    vq.push_back(mk(1,5,0,0,0, 4,3,2,1, 0));
    vq.push_back(mk(0,0,0,0,0, 4,3,2,1, 0));
    // digit 12 ignored, held key not re-accepted
    vq.push_back(mk(0,0,0,1,0, 0,0,0,0, 0));
    vq.push_back(mk(1,12,0,0,0, 0,0,0,0, 0));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0, 0));
    vq.push_back(mk(1,7,0,0,0, 7,0,0,0, 0));
    vq.push_back(mk(1,8,0,0,0, 7,0,0,0, 0));
    vq.push_back(mk(1,8,0,0,0, 7,0,0,0, 0));
    vq.push_back(mk(0,0,0,0,0, 7,0,0,0, 0));
    // 5: start+key in ENTRY -> LOAD, buffer unchanged; clear+timer_done in RUN
    vq.push_back(mk(1,5,1,0,0, 7,0,0,0, 8));
    vq.push_back(mk(0,0,0,0,0, 7,0,0,0, 4));
    vq.push_back(mk(0,0,0,1,1, 0,0,0,0, 0));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0, 0));
    vq.push_back(mk(0,0,0,0,1, 0,0,0,0, 0));
    // clear during LOAD
    vq.push_back(mk(1,2,0,0,0, 2,0,0,0, 0));
    vq.push_back(mk(0,0,0,0,0, 2,0,0,0, 0));
    vq.push_back(mk(0,0,1,0,0, 2,0,0,0, 8));
    vq.push_back(mk(0,0,0,1,0, 0,0,0,0, 0));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0, 0));
    // all-zero buffer rejected
    vq.push_back(mk(1,0,0,0,0, 0,0,0,0, 0));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0, 0));
    vq.push_back(mk(0,0,1,0,0, 0,0,0,0, 1));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0, 0));
    vq.push_back(mk(0,0,0,1,0, 0,0,0,0, 0));

    #3;
    check("reset_state", act(), 19'd0);
    #7;
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].kv, vq[i].kd, vq[i].st, vq[i].cl, vq[i].td);
      check($sformatf("vec%0d", i), act(), vq[i].exp);
    end

    // 6: async reset mid-RUN with 00:25 loaded
    cyc(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check("load_before_reset", act(), pk(5,2,0,0,8));
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("run_before_reset", act(), pk(5,2,0,0,4));
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_mid_run", act(), 19'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("after_reset_release", act(), 19'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
